wb_regfile_burst: RTL and testbench

- Parametrised Wishbone B4 slave register file. Generalises the single-purpose control slave into N read/write control words and M read-only status words.
- Adds incrementing bursts with BTE wrap, self-clearing pulse bits, per-register write strobes, read-acknowledge strobes, and ERR for illegal accesses.
- Sits between the PCI-to-Wishbone bridge and per-subsystem logic (SPI, JTAG mux, trigger).

---
 rtl/wb_regfile_burst_if.sv | 25 ++
 rtl/wb_regfile_burst.sv | 138 +++++++++++++
 tb/tb_wb_regfile_burst.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/wb_regfile_burst_if.sv
// rtl/wb_regfile_burst_if.sv - Wishbone B4 slave bus bundle for the register file
interface wb_regfile_burst_if;
  logic        cyc_i;
  logic        stb_i;
  logic        we_i;
  logic [31:0] adr_i;
  logic [31:0] dat_i;
  logic [3:0]  sel_i;
  logic [2:0]  cti_i;
  logic [1:0]  bte_i;
  logic [31:0] dat_o;
  logic        ack_o;
  logic        err_o;
  logic        rty_o;

  modport slave (
    input  cyc_i, stb_i, we_i, adr_i, dat_i, sel_i, cti_i, bte_i,
    output dat_o, ack_o, err_o, rty_o
  );

  modport master (
    output cyc_i, stb_i, we_i, adr_i, dat_i, sel_i, cti_i, bte_i,
    input  dat_o, ack_o, err_o, rty_o
  );
endinterface

// File: rtl/wb_regfile_burst.sv
// rtl/wb_regfile_burst.sv - Wishbone B4 register file with R/W control and RO status words
// Classic cycles take one wait state; incrementing/constant bursts ack with zero wait states.
module wb_regfile_burst #(
  parameter int NUM_CTRL = 8,
  parameter int NUM_STAT = 4,
  parameter int AW = 10,
  parameter logic [NUM_CTRL*32-1:0] CTRL_RESET = '0,
  parameter logic [NUM_CTRL*32-1:0] PULSE_MASK = '0
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  wb_regfile_burst_if.slave        wb,
  output logic [NUM_CTRL*32-1:0]   ctrl_o,
  output logic [NUM_CTRL-1:0]      ctrl_wr_o,
  input  logic [NUM_STAT*32-1:0]   stat_i,
  output logic [NUM_STAT-1:0]      stat_rd_o
);
  typedef enum logic [1:0] {IDLE, SINGLE, BURST, ERR} state_t;

  localparam logic [31:0] NC = 32'(NUM_CTRL);
  localparam logic [31:0] NT = 32'(NUM_CTRL + NUM_STAT);

  state_t        state;
  logic [AW-1:0] a;
  logic [AW-1:0] adr_idx;
  logic [AW-1:0] a_nxt;
  logic [AW-1:0] rd_idx;
  logic [31:0]   rd_data;
  logic [31:0]   ctrl_q [NUM_CTRL];
  logic [31:0]   ctrl_d [NUM_CTRL];
  logic          burst_beat, burst_ok, burst_bad;
  logic          commit, wr_commit, rd_commit;
  logic          unused_adr;

  function automatic logic [31:0] ext(input logic [AW-1:0] i);
    return {{(32-AW){1'b0}}, i};
  endfunction

  function automatic logic legal(input logic [AW-1:0] i, input logic we);
    return we ? (ext(i) < NC) : (ext(i) < NT);
  endfunction

  assign adr_idx    = wb.adr_i[AW+1:2];
  assign unused_adr = ^{wb.adr_i[31:AW+2], wb.adr_i[1:0]};

  // In a burst the beat at the current address is acked or errored combinationally.
  assign burst_beat = (state == BURST) && wb.cyc_i && wb.stb_i;
  assign burst_ok   = burst_beat && legal(a, wb.we_i);
  assign burst_bad  = burst_beat && !legal(a, wb.we_i);
  assign commit     = ((state == SINGLE) && wb.cyc_i && wb.stb_i) || burst_ok;
  assign wr_commit  = commit && wb.we_i;
  assign rd_commit  = commit && !wb.we_i;

  assign wb.ack_o = (state == SINGLE) || burst_ok;
  assign wb.err_o = (state == ERR) || burst_bad;
  assign wb.rty_o = 1'b0;

  always_comb begin
    a_nxt = a;
    if (wb.cti_i == 3'b010) begin
      case (wb.bte_i)
        2'b00:   a_nxt = a + AW'(1);
        2'b01:   a_nxt[1:0] = a[1:0] + 2'd1;
        2'b10:   a_nxt[2:0] = a[2:0] + 3'd1;
        default: a_nxt[3:0] = a[3:0] + 4'd1;
      endcase
    end
  end

  // One read mux serves both the first-beat load and the per-beat reload.
  always_comb begin
    rd_idx  = (state == IDLE) ? adr_idx : a_nxt;
    rd_data = '0;
    for (int k = 0; k < NUM_CTRL; k++)
      if (ext(rd_idx) == 32'(k)) rd_data = ctrl_q[k];
    for (int j = 0; j < NUM_STAT; j++)
      if (ext(rd_idx) == NC + 32'(j)) rd_data = stat_i[32*j +: 32];
  end

  // Pulse bits clear every cycle unless the same cycle writes them again.
  always_comb begin
    for (int k = 0; k < NUM_CTRL; k++) begin
      ctrl_d[k] = ctrl_q[k] & ~PULSE_MASK[32*k +: 32];
      if (wr_commit && ext(a) == 32'(k))
        for (int b = 0; b < 4; b++)
          if (wb.sel_i[b]) ctrl_d[k][8*b +: 8] = wb.dat_i[8*b +: 8];
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_CTRL; k++) ctrl_o[32*k +: 32] = ctrl_q[k];
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state     <= IDLE;
      a         <= '0;
      wb.dat_o  <= '0;
      ctrl_wr_o <= '0;
      stat_rd_o <= '0;
      for (int k = 0; k < NUM_CTRL; k++) ctrl_q[k] <= CTRL_RESET[32*k +: 32];
    end else begin
      for (int k = 0; k < NUM_CTRL; k++) begin
        ctrl_q[k]    <= ctrl_d[k];
        ctrl_wr_o[k] <= wr_commit && (ext(a) == 32'(k));
      end
      for (int j = 0; j < NUM_STAT; j++)
        stat_rd_o[j] <= rd_commit && (ext(a) == NC + 32'(j));
      case (state)
        IDLE: begin
          if (wb.cyc_i && wb.stb_i) begin
            a        <= adr_idx;
            wb.dat_o <= rd_data;
            if (!legal(adr_idx, wb.we_i)) state <= ERR;
            else begin
              case (wb.cti_i)
                3'b000, 3'b111: state <= SINGLE;
                3'b001, 3'b010: state <= BURST;
                default:        state <= ERR;
              endcase
            end
          end
        end
        SINGLE: state <= IDLE;
        ERR:    state <= IDLE;
        BURST: begin
          if (!wb.cyc_i || burst_bad) state <= IDLE;
          else if (burst_ok) begin
            a        <= a_nxt;
            wb.dat_o <= rd_data;
            if (wb.cti_i == 3'b111) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_regfile_burst.sv
// tb/tb_wb_regfile_burst.sv - scoreboard bench for wb_regfile_burst
// Driver pushes expected ack/err responses; a negedge monitor pops and compares them.
module tb_wb_regfile_burst;
  localparam int NUM_CTRL = 8;
  localparam int NUM_STAT = 4;
  localparam logic [255:0] RST_VAL = {32'h0, 32'h0, 32'h0, 32'h0,
                                      32'h99AABBCC, 32'h55667788, 32'h00000000, 32'h11223344};
  localparam logic [255:0] AFTER_W2 = {32'h0, 32'h0, 32'h0, 32'h0,
                                       32'h99AABBCC, 32'h55BB77DD, 32'h00000000, 32'h11223344};
  localparam logic [255:0] PMASK = 256'h1 << 32;

  typedef struct packed {
    logic        is_err;
    logic        chk;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [NUM_CTRL*32-1:0] ctrl;
  logic [NUM_CTRL-1:0]    ctrl_wr;
  logic [NUM_STAT*32-1:0] stat = {32'hC0DE0003, 32'hC0DE0002, 32'hC0DE0001, 32'hC0DE0000};
  logic [NUM_STAT-1:0]    stat_rd;
  exp_t q[$];
  int total = 0;
  int bad = 0;
  int lat;
  logic [15:0] hist;

  wb_regfile_burst_if bus();

  wb_regfile_burst #(
    .NUM_CTRL(NUM_CTRL), .NUM_STAT(NUM_STAT), .AW(10),
    .CTRL_RESET(RST_VAL), .PULSE_MASK(PMASK)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n), .wb(bus),
    .ctrl_o(ctrl), .ctrl_wr_o(ctrl_wr), .stat_i(stat), .stat_rd_o(stat_rd)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic push(input logic is_err, input logic chk, input logic [31:0] d);
    exp_t e;
    e.is_err = is_err;
    e.chk    = chk;
    e.data   = d;
    q.push_back(e);
  endtask

  // Monitor: every ack or err the DUT presents must match the head of the queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.ack_o || bus.err_o) begin
        if (q.size() == 0) begin
          check("sb_unexpected_resp", 256'({bus.ack_o, bus.err_o}), 256'(0));
        end else begin
          e = q.pop_front();
          check("sb_resp_kind", 256'({bus.ack_o, bus.err_o}), 256'({!e.is_err, e.is_err}));
          if (e.chk) check("sb_read_data", 256'(bus.dat_o), 256'(e.data));
        end
      end
    end
  end

  task automatic wait_resp(output int w);
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!(bus.ack_o || bus.err_o) && w < 20);
    if (!(bus.ack_o || bus.err_o)) check("resp_timeout", 256'(0), 256'(1));
  endtask

  task automatic classic(input logic we, input int idx, input logic [31:0] d,
                         input logic [3:0] sel, input logic [2:0] cti, output int l);
    @(posedge clk); #1;
    bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = we;
    bus.adr_i = 32'(idx) << 2; bus.dat_i = d; bus.sel_i = sel;
    bus.cti_i = cti; bus.bte_i = 2'b00;
    wait_resp(l);
    @(posedge clk); #1;
    bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.cti_i = 3'b000;
  endtask

  task automatic burst(input logic we, input int idx, input logic [31:0] d, input logic [3:0] sel,
                       input logic [2:0] mode, input logic [1:0] bte, input int n,
                       output int cycles, output logic [15:0] h);
    int w;
    @(posedge clk); #1;
    bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = we;
    bus.adr_i = 32'(idx) << 2; bus.dat_i = d; bus.sel_i = sel; bus.bte_i = bte;
    cycles = 0;
    h = '0;
    for (int i = 0; i < n; i++) begin
      bus.cti_i = (i == n - 1) ? 3'b111 : mode;
      wait_resp(w);
      cycles += w;
      h[i] = ctrl[32];
      @(posedge clk); #1;
    end
    bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.cti_i = 3'b000;
  endtask

  initial begin
    bus.cyc_i = 0; bus.stb_i = 0; bus.we_i = 0; bus.adr_i = 0;
    bus.dat_i = 0; bus.sel_i = 0; bus.cti_i = 0; bus.bte_i = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl", ctrl, RST_VAL);
    check("rst_ack_err_rty", 256'({bus.ack_o, bus.err_o, bus.rty_o}), 256'(0));
    check("rst_dat", 256'(bus.dat_o), 256'(0));
    check("rst_pulses", 256'({ctrl_wr, stat_rd}), 256'(0));
    @(posedge clk); #1; reset_n = 1'b1;

    push(1'b0, 1'b1, 32'h11223344);
    classic(1'b0, 0, 32'h0, 4'hF, 3'b000, lat);
    check("classic_rd_latency", 256'(lat), 256'(2));

    push(1'b0, 1'b0, 32'h0);
    classic(1'b1, 2, 32'hAABBCCDD, 4'b0101, 3'b000, lat);
    @(negedge clk);
    check("wr_sel_ctrl", ctrl, AFTER_W2);
    check("ctrl_wr_pulse", 256'(ctrl_wr), 256'(8'b0000_0100));
    @(negedge clk);
    check("ctrl_wr_clear", 256'(ctrl_wr), 256'(0));

    push(1'b0, 1'b1, 32'h55BB77DD);
    classic(1'b0, 2, 32'h0, 4'hF, 3'b111, lat);

    push(1'b0, 1'b1, 32'h55BB77DD);
    push(1'b0, 1'b1, 32'h99AABBCC);
    push(1'b0, 1'b1, 32'h11223344);
    push(1'b0, 1'b1, 32'h00000000);
    burst(1'b0, 2, 32'h0, 4'hF, 3'b010, 2'b01, 4, lat, hist);
    check("burst_wrap_cycles", 256'(lat), 256'(5));

    push(1'b0, 1'b1, 32'hC0DE0001);
    classic(1'b0, 9, 32'h0, 4'hF, 3'b000, lat);
    @(negedge clk);
    check("stat_rd_pulse", 256'(stat_rd), 256'(4'b0010));
    @(negedge clk);
    check("stat_rd_clear", 256'(stat_rd), 256'(0));

    push(1'b1, 1'b0, 32'h0);
    classic(1'b1, NUM_CTRL, 32'hFFFFFFFF, 4'hF, 3'b000, lat);
    check("err_latency", 256'(lat), 256'(2));
    push(1'b1, 1'b0, 32'h0);
    classic(1'b0, 0, 32'h0, 4'hF, 3'b011, lat);
    push(1'b1, 1'b0, 32'h0);
    classic(1'b0, 12, 32'h0, 4'hF, 3'b000, lat);
    @(negedge clk);
    check("err_no_side_effect", ctrl, AFTER_W2);

    push(1'b0, 1'b0, 32'h0);
    classic(1'b1, 1, 32'h00000001, 4'b0001, 3'b000, lat);
    @(negedge clk);
    check("pulse_high", 256'(ctrl[32]), 256'(1));
    @(negedge clk);
    check("pulse_cleared", 256'(ctrl[32]), 256'(0));

    push(1'b0, 1'b0, 32'h0);
    push(1'b0, 1'b0, 32'h0);
    push(1'b0, 1'b0, 32'h0);
    burst(1'b1, 1, 32'h00000001, 4'b0001, 3'b001, 2'b00, 3, lat, hist);
    check("pulse_burst_held", 256'(hist[2:0]), 256'(3'b110));
    check("pulse_burst_cycles", 256'(lat), 256'(4));
    @(negedge clk);
    check("pulse_burst_last", 256'(ctrl[32]), 256'(1));
    @(negedge clk);
    check("pulse_burst_clear", 256'(ctrl[32]), 256'(0));

    @(posedge clk); #1;
    bus.cyc_i = 1; bus.stb_i = 1; bus.we_i = 1; bus.adr_i = 32'd16;
    bus.dat_i = 32'hDEAD0004; bus.sel_i = 4'hF; bus.cti_i = 3'b010; bus.bte_i = 2'b00;
    push(1'b0, 1'b0, 32'h0);
    push(1'b0, 1'b0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    check("rst_burst_beat0_ack", 256'(bus.ack_o), 256'(1));
    @(posedge clk); #1;
    bus.dat_i = 32'hDEAD0005;
    reset_n = 1'b0;
    @(negedge clk);
    check("rst_burst_beat0_commit", 256'(ctrl[159:128]), 256'(32'hDEAD0004));
    @(posedge clk); #1;
    bus.cyc_i = 0; bus.stb_i = 0; bus.cti_i = 3'b000;
    @(negedge clk);
    check("rst_burst_ack_drop", 256'(bus.ack_o), 256'(0));
    check("rst_burst_ctrl", ctrl, RST_VAL);
    check("rst_burst_no_wr", 256'(ctrl_wr), 256'(0));
    @(posedge clk); #1; reset_n = 1'b1;

    push(1'b0, 1'b1, 32'h00000000);
    classic(1'b0, 5, 32'h0, 4'hF, 3'b000, lat);
    repeat (2) @(negedge clk);
    check("sb_drained", 256'(q.size()), 256'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
